conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Sliding-window generator for the convolution datapath. It accepts the raster pixel stream read from image memory, where the address generator advances one address per accepted pixel. It buffers KERNEL_SIZE-1 image rows and presents one full KERNEL_SIZE x KERNEL_SIZE window per valid output position to the convolution MAC stage, with ready/valid back-pressure. There is no padding: only windows lying fully inside the image are emitted.

## Interface
- IMAGE_WIDTH, 4, pixels per row
- IMAGE_HEIGHT, 4, rows per frame
- KERNEL_SIZE, 3, window edge (K); 2 <= K <= min(IMAGE_WIDTH, IMAGE_HEIGHT)
- DATA_WIDTH, 8, bits per pixel
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous active-low reset
- pix_valid  input  1  pix_data holds a valid pixel
- pix_data  input  DATA_WIDTH  pixel value, raster order, row 0 col 0 first
- pix_ready  output  1  block can accept a pixel this cycle; address-generator wr_en = pix_valid & pix_ready
- win_valid  output  1  window holds a valid window
- win_ready  input  1  downstream accepts the window this cycle
- window  output  K*K*DATA_WIDTH  element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest (top) row, c=0 the leftmost column
- win_last  output  1  qualifies win_valid: this is the final window of the frame

## Operation
- Accept: pix_valid & pix_ready. pix_ready = !win_valid | win_ready (combinational).
- Counters col (0..IMAGE_WIDTH-1) and row (0..IMAGE_HEIGHT-1) give the position of the next pixel to accept. Width of each is $clog2 of its range, minimum 1.
- On accept: col increments. At IMAGE_WIDTH-1, col wraps to 0 and row increments. At the last pixel of the frame (row IMAGE_HEIGHT-1, col IMAGE_WIDTH-1), both wrap to 0 and the next accept starts a new frame.
- Line buffers: K-1 row FIFOs of depth IMAGE_WIDTH, shifted once per accept. Each row-buffer tap at column col gives the same column from the K-1 previous rows.
- Window register: K x K. On every accept, columns shift left (c to c-1). The new column c=K-1 is loaded with the K-1 line-buffer taps, oldest in r=0, plus pix_data in r=K-1.
- Window emit: when the accepted pixel has row >= K-1 and col >= K-1, win_valid is set next cycle. win_last is set if that pixel is the last of the frame.
- Output register:
  - win_valid & win_ready with no new emitting accept: win_valid clears.
  - win_valid & !win_ready: window, win_valid and win_last hold. pix_ready=0, so nothing shifts.
  - Accept that emits while win_ready=1: the new window replaces the old one with no bubble.
- Accepts with row < K-1 or col < K-1 fill the buffers only. win_valid clears if the current window was taken that cycle.
- Windows per frame: (IMAGE_WIDTH-K+1)*(IMAGE_HEIGHT-K+1). Frames run back to back with no gap required.

## Timing
- Reset (rst low, asynchronous): col=0, row=0, win_valid=0, win_last=0, window=0. Window-register contents are zeroed. Line-buffer contents are don't-care and need no reset.
- pix_ready is 1 during and after reset, since win_valid=0.
- Reset mid-frame aborts the frame. The first accept after release is treated as row 0, col 0, and no stale window is emitted.
- Latency: exactly 1 cycle from an emitting accept to win_valid=1 with the corresponding window.
- Throughput: one pixel per cycle while win_ready=1.
- While win_valid=1 and win_ready=0, window/win_last are stable and pix_ready=0. pix_valid may toggle freely.
- pix_data is ignored when pix_valid=0 or pix_ready=0.
- State is unchanged on cycles with no accept, except win_valid clearing on handshake.

## Test plan
- 4x4, K=3, pixels 0..15, win_ready=1: exactly 4 windows, at the cycles after accepting pixels 10, 11, 14, 15.
  - First window = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15}.
  - win_last=1 only on the last window.
- Same stream with win_ready=0 for 3 cycles after the first window: window holds {0..10 set}, pix_ready=0, and pixel 11 is not consumed. After release, the remaining 3 windows are correct and in order.
- Two back-to-back frames (values 0..15, then 100..115): the second frame's first window = {100,101,102,104,105,106,108,109,110`}` with no cross-frame mixing.
- pix_valid toggling 1/0 every cycle: same 4 windows as test 1, each 1 cycle after its emitting accept.
- Reset asserted after pixel 7, then a fresh 0..15 frame: outputs are 0 during reset and the window set is identical to test 1.
- IMAGE_WIDTH=5, IMAGE_HEIGHT=4, K=2, ramp 0..19: 12 windows, first {0,1,5,6}, last {13,14,18,19} with win_last=1.

Source files
------------

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - sliding KxK window generator over a raster pixel stream
module conv_window_gen #(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              pix_valid,
  input  logic [DATA_WIDTH-1:0]                             pix_data,
  output logic                                              pix_ready,
  output logic                                              win_valid,
  input  logic                                              win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     window,
  output logic                                              win_last
);

  localparam int K        = KERNEL_SIZE;
  localparam int CW       = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW       = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int LB_DEPTH = (K - 1) * IMAGE_WIDTH;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] win_q [K][K];
  logic [DATA_WIDTH-1:0] win_d [K][K];
  logic [DATA_WIDTH-1:0] lb_q  [LB_DEPTH];

  logic accept;
  logic col_end;
  logic row_end;
  logic emit;
  logic frame_end;
  logic taken;

  // A held window blocks intake so the window register cannot shift under it
  assign pix_ready = !valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_end   = (col_q == CW'(IMAGE_WIDTH - 1));
  assign row_end   = (row_q == RW'(IMAGE_HEIGHT - 1));
  assign frame_end = accept && col_end && row_end;
  assign emit      = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign taken     = valid_q && win_ready;

  // Raster position of the next pixel, wrapping at row and frame ends
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffer: one shift chain of K-1 rows; entry W*j-1 is the same column j rows back.
  // Contents are never used before being refilled after reset, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0] <= pix_data;
      for (int i = 1; i < LB_DEPTH; i++) begin
        lb_q[i] <= lb_q[i-1];
      end
    end
  end

  // Window shifts left one column per accept; new right column comes from the taps plus the input
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = lb_q[(K - 1 - r) * IMAGE_WIDTH - 1];
      end
      win_d[K-1][K-1] = pix_data;
    end
  end

  // Window register, cleared on reset so no stale data is ever visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  // Output qualifiers: a new emit overrides a handshake so windows stream with no bubble
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    if (emit) begin
      valid_d = 1'b1;
      last_d  = frame_end;
    end else if (taken) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Output qualifier registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Flatten the window, element (r,c) at index r*K+c
  always_comb begin
    window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
      end
    end
  end

  assign win_valid = valid_q;
  assign win_last  = last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboard bench for conv_window_gen
module tb_conv_window_gen;

  localparam int DW  = 8;
  localparam int AW  = 4, AH = 4, AK = 3;
  localparam int BW  = 5, BH = 4, BK = 2;
  localparam int AWB = AK*AK*DW;
  localparam int BWB = BK*BK*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;

  // DUT A: 4x4, K=3
  logic           a_rst, a_pv, a_pr, a_wv, a_wr, a_wl;
  logic [DW-1:0]  a_pd;
  logic [AWB-1:0] a_win;
  int             a_rmode = 0;

  conv_window_gen #(.IMAGE_WIDTH(AW), .IMAGE_HEIGHT(AH), .KERNEL_SIZE(AK), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst(a_rst), .pix_valid(a_pv), .pix_data(a_pd), .pix_ready(a_pr),
    .win_valid(a_wv), .win_ready(a_wr), .window(a_win), .win_last(a_wl));

  // DUT B: 5x4, K=2
  logic           b_rst, b_pv, b_pr, b_wv, b_wr, b_wl;
  logic [DW-1:0]  b_pd;
  logic [BWB-1:0] b_win;
  int             b_rmode = 0;

  conv_window_gen #(.IMAGE_WIDTH(BW), .IMAGE_HEIGHT(BH), .KERNEL_SIZE(BK), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .rst(b_rst), .pix_valid(b_pv), .pix_data(b_pd), .pix_ready(b_pr),
    .win_valid(b_wv), .win_ready(b_wr), .window(b_win), .win_last(b_wl));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AWB-1:0] packa(input int v[AK*AK]);
    logic [AWB-1:0] p;
    for (int i = 0; i < AK*AK; i++) p[i*DW +: DW] = DW'(v[i]);
    return p;
  endfunction

  function automatic logic [BWB-1:0] packb(input int v[BK*BK]);
    logic [BWB-1:0] p;
    for (int i = 0; i < BK*BK; i++) p[i*DW +: DW] = DW'(v[i]);
    return p;
  endfunction

  typedef struct { logic [AWB-1:0] win; logic last; int cyc; } a_exp_t;
  typedef struct { logic [BWB-1:0] win; logic last; int cyc; } b_exp_t;

  a_exp_t a_q[$];
  b_exp_t b_q[$];

  // Reference model A: store the frame, cut out the window when its bottom-right pixel arrives
  int a_img [AH][AW];
  int a_row = 0, a_col = 0;
  always @(negedge clk) begin : a_model
    a_exp_t e;
    if (!a_rst) begin
      a_row = 0; a_col = 0; a_q.delete();
    end else if (a_pv && a_pr) begin
      a_img[a_row][a_col] = int'(a_pd);
      if (a_row >= AK-1 && a_col >= AK-1) begin
        for (int r = 0; r < AK; r++)
          for (int c = 0; c < AK; c++)
            e.win[(r*AK+c)*DW +: DW] = DW'(a_img[a_row-AK+1+r][a_col-AK+1+c]);
        e.last = (a_row == AH-1) && (a_col == AW-1);
        e.cyc  = cyc + 1;
        a_q.push_back(e);
      end
      a_col++;
      if (a_col == AW) begin a_col = 0; a_row++; if (a_row == AH) a_row = 0; end
    end
  end

  int b_img [BH][BW];
  int b_row = 0, b_col = 0;
  always @(negedge clk) begin : b_model
    b_exp_t e;
    if (!b_rst) begin
      b_row = 0; b_col = 0; b_q.delete();
    end else if (b_pv && b_pr) begin
      b_img[b_row][b_col] = int'(b_pd);
      if (b_row >= BK-1 && b_col >= BK-1) begin
        for (int r = 0; r < BK; r++)
          for (int c = 0; c < BK; c++)
            e.win[(r*BK+c)*DW +: DW] = DW'(b_img[b_row-BK+1+r][b_col-BK+1+c]);
        e.last = (b_row == BH-1) && (b_col == BW-1);
        e.cyc  = cyc + 1;
        b_q.push_back(e);
      end
      b_col++;
      if (b_col == BW) begin b_col = 0; b_row++; if (b_row == BH) b_row = 0; end
    end
  end

  // Output monitor A
  logic           a_seen = 0, a_hold = 0, a_prevl = 0;
  int             a_pcyc = 0, a_nwin = 0;
  logic [AWB-1:0] a_prev = '0;
  logic [AWB-1:0] a_log[$];
  always @(negedge clk) begin : a_mon
    a_exp_t e;
    if (!a_rst) begin
      a_seen = 0; a_hold = 0;
    end else begin
      chk("a_pix_ready", a_pr, !a_wv || a_wr);
      if (a_hold) chk("a_hold_stable", {a_wv, a_wl, a_win}, {1'b1, a_prevl, a_prev});
      if (a_wv && !a_seen) begin a_seen = 1; a_pcyc = cyc; end
      if (a_wv && a_wr) begin
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_window: got %0h expected none", a_win);
        end else begin
          e = a_q.pop_front();
          chk("a_window", a_win, e.win);
          chk("a_win_last", a_wl, e.last);
          chk("a_latency", a_pcyc, e.cyc);
        end
        a_log.push_back(a_win);
        a_nwin++;
        a_seen = 0;
      end
      a_hold = a_wv && !a_wr; a_prev = a_win; a_prevl = a_wl;
    end
  end

  // Output monitor B
  logic           b_seen = 0, b_hold = 0, b_prevl = 0;
  int             b_pcyc = 0, b_nwin = 0;
  logic [BWB-1:0] b_prev = '0;
  logic [BWB-1:0] b_log[$];
  logic           b_llog[$];
  always @(negedge clk) begin : b_mon
    b_exp_t e;
    if (!b_rst) begin
      b_seen = 0; b_hold = 0;
    end else begin
      chk("b_pix_ready", b_pr, !b_wv || b_wr);
      if (b_hold) chk("b_hold_stable", {b_wv, b_wl, b_win}, {1'b1, b_prevl, b_prev});
      if (b_wv && !b_seen) begin b_seen = 1; b_pcyc = cyc; end
      if (b_wv && b_wr) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_window: got %0h expected none", b_win);
        end else begin
          e = b_q.pop_front();
          chk("b_window", b_win, e.win);
          chk("b_win_last", b_wl, e.last);
          chk("b_latency", b_pcyc, e.cyc);
        end
        b_log.push_back(b_win);
        b_llog.push_back(b_wl);
        b_nwin++;
        b_seen = 0;
      end
      b_hold = b_wv && !b_wr; b_prev = b_win; b_prevl = b_wl;
    end
  end

  // Random back-pressure drivers
  initial forever begin
    @(posedge clk); #1;
    if (a_rmode == 1) a_wr = 1'($urandom_range(0, 1));
    if (b_rmode == 1) b_wr = 1'($urandom_range(0, 1));
  end

  task automatic a_send(input int v, input int gap);
    int guard = 0;
    logic acc;
    a_pv = 1'b1; a_pd = DW'(v);
    do begin
      @(negedge clk); acc = a_pr; @(posedge clk); #1; guard++;
    end while (!acc && guard < 200);
    if (!acc) begin checks++; errors++; $display("FAIL a_send_timeout: got stalled expected accept of %0d", v); end
    a_pv = 1'b0; a_pd = DW'($urandom_range(0, 255));
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic b_send(input int v, input int gap);
    int guard = 0;
    logic acc;
    b_pv = 1'b1; b_pd = DW'(v);
    do begin
      @(negedge clk); acc = b_pr; @(posedge clk); #1; guard++;
    end while (!acc && guard < 200);
    if (!acc) begin checks++; errors++; $display("FAIL b_send_timeout: got stalled expected accept of %0d", v); end
    b_pv = 1'b0; b_pd = DW'($urandom_range(0, 255));
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // gmode: 0 no gap, 1 alternate, 2 random gap
  task automatic a_frame(input int base, input int gmode, input logic rnd);
    for (int i = 0; i < AW*AH; i++)
      a_send(rnd ? int'($urandom_range(0, 255)) : base + i,
             gmode == 1 ? 1 : (gmode == 2 ? int'($urandom_range(0, 2)) : 0));
  endtask

  task automatic b_frame(input int base, input int gmode, input logic rnd);
    for (int i = 0; i < BW*BH; i++)
      b_send(rnd ? int'($urandom_range(0, 255)) : base + i,
             gmode == 1 ? 1 : (gmode == 2 ? int'($urandom_range(0, 2)) : 0));
  endtask

  task automatic a_drain();
    int guard = 0;
    a_rmode = 0; a_wr = 1'b1; a_pv = 1'b0;
    while ((a_q.size() != 0 || a_wv) && guard < 50) begin @(posedge clk); #1; guard++; end
    repeat (2) begin @(posedge clk); #1; end
    chk("a_drain_empty", a_q.size(), 0);
  endtask

  task automatic b_drain();
    int guard = 0;
    b_rmode = 0; b_wr = 1'b1; b_pv = 1'b0;
    while ((b_q.size() != 0 || b_wv) && guard < 50) begin @(posedge clk); #1; guard++; end
    repeat (2) begin @(posedge clk); #1; end
    chk("b_drain_empty", b_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int va1[AK*AK], va2[AK*AK], va3[AK*AK];
    int vb1[BK*BK], vb2[BK*BK];
    va1 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    va2 = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    va3 = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
    vb1 = '{0, 1, 5, 6};
    vb2 = '{13, 14, 18, 19};

    a_rst = 0; a_pv = 0; a_pd = '0; a_wr = 1;
    b_rst = 0; b_pv = 0; b_pd = '0; b_wr = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_reset_outputs", {a_wv, a_wl, a_pr, a_win}, {1'b0, 1'b0, 1'b1, {AWB{1'b0}}});
    chk("b_reset_outputs", {b_wv, b_wl, b_pr, b_win}, {1'b0, 1'b0, 1'b1, {BWB{1'b0}}});
    @(posedge clk); #1;
    a_rst = 1; b_rst = 1;

    // Plain ramp frame
    n0 = a_nwin;
    a_frame(0, 0, 0);
    a_drain();
    chk("t1_count", a_nwin - n0, 4);
    chk("t1_first", a_log[n0], packa(va1));
    chk("t1_last", a_log[n0+3], packa(va2));

    // Stall after the first window
    n0 = a_nwin;
    for (int i = 0; i < AW*AH; i++) begin
      if (i == 11) begin
        a_wr = 1'b0; a_pv = 1'b1; a_pd = DW'(11);
        repeat (3) begin
          @(negedge clk);
          chk("t2_stall", {a_pr, a_wv, a_win}, {1'b0, 1'b1, packa(va1)});
          @(posedge clk); #1;
        end
        a_wr = 1'b1;
      end
      a_send(i, 0);
    end
    a_drain();
    chk("t2_count", a_nwin - n0, 4);
    chk("t2_last", a_log[n0+3], packa(va2));

    // Back-to-back frames
    n0 = a_nwin;
    a_frame(0, 0, 0);
    a_frame(100, 0, 0);
    a_drain();
    chk("t3_count", a_nwin - n0, 8);
    chk("t3_frame2_first", a_log[n0+4], packa(va3));

    // pix_valid toggling
    n0 = a_nwin;
    a_frame(0, 1, 0);
    a_drain();
    chk("t4_count", a_nwin - n0, 4);

    // Mid-frame reset after pixel 7
    for (int i = 0; i < 8; i++) a_send(i, 0);
    a_rst = 1'b0;
    @(negedge clk);
    chk("t5_reset_outputs", {a_wv, a_wl, a_pr, a_win}, {1'b0, 1'b0, 1'b1, {AWB{1'b0}}});
    @(posedge clk); #1;
    a_rst = 1'b1;
    n0 = a_nwin;
    a_frame(0, 0, 0);
    a_drain();
    chk("t5_count", a_nwin - n0, 4);
    chk("t5_first", a_log[n0], packa(va1));
    chk("t5_last", a_log[n0+3], packa(va2));

    // Random data, gaps and back-pressure
    n0 = a_nwin;
    a_rmode = 1;
    repeat (3) a_frame(0, 2, 1);
    a_drain();
    chk("t6_count", a_nwin - n0, 12);

    // 5x4, K=2 ramp
    n0 = b_nwin;
    b_frame(0, 0, 0);
    b_drain();
    chk("t7_count", b_nwin - n0, 12);
    chk("t7_first", b_log[n0], packb(vb1));
    chk("t7_last", {b_llog[n0+11], b_log[n0+11]}, {1'b1, packb(vb2)});
    chk("t7_not_last", b_llog[n0+10], 0);

    // 5x4 random
    n0 = b_nwin;
    b_rmode = 1;
    repeat (2) b_frame(0, 2, 1);
    b_drain();
    chk("t8_count", b_nwin - n0, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
